// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA console and its write scheduler:
// scheduler state encoding, ASCII control codes and console geometry.
package vga_console_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_GUARD       = 2'd2,
        ST_WAIT_SCROLL = 2'd3
    } sched_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    // Console geometry, shared with vga_console.
    localparam int CON_MAX_X = 30;
    localparam int CON_MAX_Y = 30;

    // Bytes with bit 7 set are outside the console font and are discarded.
    function automatic logic is_high_byte(input logic [7:0] b);
        return b[7];
    endfunction

endpackage

// File: rtl/vga_console_sched_if.sv
// CPU-side character write port of the console scheduler.
//
// Handshake: a byte transfers on a rising clk edge where wr_valid and
// wr_ready are both high. wr_ready does not depend on wr_valid. The master
// holds wr_data stable while wr_valid is high and wr_ready is low.
interface vga_console_sched_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/sync_char_fifo.sv
// Single-clock character FIFO with show-ahead read data and a registered
// occupancy count. A push into a full FIFO is refused even when a pop
// happens in the same cycle.
module sync_char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_console_sched.sv
// Write scheduler between the CPU character port and vga_console.
// Buffers bytes, normalises the stream (CR+LF collapse, TAB expansion,
// high-byte drop) and issues single-cycle font_we pulses separated by a
// guard gap, holding off while the console is scrolling.
module vga_console_sched
    import vga_console_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int TAB_SPACES   = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    vga_console_sched_if.slave          wr_if,
    output logic                        font_we,
    output logic [7:0]                  font_data,
    input  logic                        scroll,
    output logic                        busy,
    output logic [7:0]                  drop_count,
    output sched_state_t                dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_INIT    = GW'(GUARD_CYCLES - 1);
    localparam logic [3:0]    TAB_REM_INIT  = 4'(TAB_SPACES - 1);

    sched_state_t  state, state_next;
    logic [7:0]    cur_char, cur_char_next;
    logic [3:0]    tab_rem, tab_rem_next;
    logic [GW-1:0] guard_cnt, guard_next;
    logic          prev_cr, prev_cr_next;
    logic          drop_hit;

    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    sync_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_if.wr_valid),
        .push_data (wr_if.wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_fifo_count)
    );

    assign wr_if.wr_ready = !fifo_full;
    assign busy           = (state != ST_IDLE) || !fifo_empty;
    assign dbg_state      = state;

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, pop and classification decode.
    always_comb begin
        state_next    = state;
        fifo_pop      = 1'b0;
        cur_char_next = cur_char;
        tab_rem_next  = tab_rem;
        guard_next    = guard_cnt;
        prev_cr_next  = prev_cr;
        drop_hit      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !scroll) begin
                    fifo_pop = 1'b1;
                    if (is_high_byte(fifo_head)) begin
                        drop_hit = 1'b1;
                    end else if (fifo_head == ASCII_LF && prev_cr) begin
                        // LF completing a CR+LF pair: the CR already moved the cursor.
                        prev_cr_next = 1'b0;
                    end else if (fifo_head == ASCII_TAB) begin
                        cur_char_next = ASCII_SP;
                        tab_rem_next  = TAB_REM_INIT;
                        state_next    = ST_ISSUE;
                    end else begin
                        cur_char_next = fifo_head;
                        state_next    = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                prev_cr_next = (cur_char == ASCII_CR);
                guard_next   = GUARD_INIT;
                state_next   = ST_GUARD;
            end

            ST_GUARD: begin
                if (guard_cnt == '0) begin
                    // Last guard cycle: a scroll raised by the write just issued is visible now.
                    if (scroll) begin
                        state_next = ST_WAIT_SCROLL;
                    end else if (tab_rem != 4'd0) begin
                        tab_rem_next = tab_rem - 4'd1;
                        state_next   = ST_ISSUE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    guard_next = guard_cnt - 1'b1;
                end
            end

            ST_WAIT_SCROLL: begin
                if (!scroll) begin
                    if (tab_rem != 4'd0) begin
                        tab_rem_next = tab_rem - 4'd1;
                        state_next   = ST_ISSUE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and registered console outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_char   <= 8'h00;
            tab_rem    <= 4'd0;
            guard_cnt  <= '0;
            prev_cr    <= 1'b0;
            font_we    <= 1'b0;
            font_data  <= 8'h00;
            drop_count <= 8'h00;
        end else begin
            cur_char  <= cur_char_next;
            tab_rem   <= tab_rem_next;
            guard_cnt <= guard_next;
            prev_cr   <= prev_cr_next;
            font_we   <= (state_next == ST_ISSUE);
            if (state_next == ST_ISSUE) begin
                font_data <= cur_char_next;
            end
            if (drop_hit && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_console_sched.sv
// Bench for vga_console_sched: scoreboard of expected console bytes, pulse
// timing log, directed scenarios for latency, burst fill, CR/LF, TAB,
// drops, scroll stall and reset mid-operation.
module tb_vga_console_sched;
    import vga_console_pkg::*;

    localparam int TABN  = 4;
    localparam int GUARD = 2;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         scroll;
    logic         font_we;
    logic [7:0]   font_data;
    logic         busy;
    logic [7:0]   drop_count;
    sched_state_t dbg_state;
    logic [4:0]   dbg_fifo_count;

    vga_console_sched_if wr_if();

    vga_console_sched #(
        .FIFO_DEPTH   (16),
        .TAB_SPACES   (TABN),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_if          (wr_if),
        .font_we        (font_we),
        .font_data      (font_data),
        .scroll         (scroll),
        .busy           (busy),
        .drop_count     (drop_count),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         pulse_t[$];
    bit         m_prev_cr = 1'b0;
    int         drop_exp = 0;
    logic       prev_we = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference normalisation of one accepted byte into expected console writes.
    task automatic model_byte(input logic [7:0] b);
        if (b[7]) begin
            if (drop_exp < 255) drop_exp++;
        end else if (b == 8'h0A && m_prev_cr) begin
            m_prev_cr = 1'b0;
        end else if (b == 8'h09) begin
            for (int i = 0; i < TABN; i++) exp_q.push_back(8'h20);
            m_prev_cr = 1'b0;
        end else begin
            exp_q.push_back(b);
            m_prev_cr = (b == 8'h0D);
        end
    endtask

    // Output monitor: every pulse is logged and compared against the queue head.
    always @(negedge clk) begin
        if (!reset && font_we) begin
            pulse_t.push_back(cyc);
            check("we_during_scroll", 32'(scroll), 32'd0);
            check("we_width", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) check("unexpected_pulse", exp_q.size(), 1);
            else check("font_data", 32'(font_data), 32'(exp_q.pop_front()));
        end
        prev_we = font_we;
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b, output int acc);
        int t = 0;
        @(negedge clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = b;
        while (!wr_if.wr_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        acc = cyc;
        if (t >= 3000) begin
            check("push_timeout", t, 0);
            wr_if.wr_valid = 1'b0;
        end else begin
            model_byte(b);
            @(posedge clk);
            #1;
            wr_if.wr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        int quiet = 0;
        while (quiet < 3 && t < 5000) begin
            @(negedge clk);
            t++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, a, t, fall, idx, stall_at, n0, m, busy_low;
        reset = 1'b1;
        scroll = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_font_we", 32'(font_we), 32'd0);
        check("rst_font_data", 32'(font_data), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Single byte: pulse two cycles after acceptance, busy low five after
        pulse_t.delete();
        push_byte(8'h41, acc);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 50);
        fall = cyc;
        check("single_busy_fall", fall - acc, 5);
        wait_idle("single");
        check("single_pulses", pulse_t.size(), 1);
        if (pulse_t.size() >= 1) check("single_latency", pulse_t[0] - acc, 2);

        // Burst fill with scroll holding the FIFO, then drain at full rate
        @(posedge clk);
        #1 scroll = 1'b1;
        pulse_t.delete();
        stall_at = -1;
        idx = 0;
        wr_if.wr_valid = 1'b1;
        for (int c = 0; c < 400 && idx < 20; c++) begin
            @(negedge clk);
            if (c == 30) begin
                check("fill_count", 32'(dbg_fifo_count), 32'd16);
                scroll = 1'b0;
            end
            wr_if.wr_data = 8'h30 + idx[7:0];
            if (wr_if.wr_ready) begin
                model_byte(wr_if.wr_data);
                idx++;
            end else if (stall_at < 0) begin
                stall_at = idx;
            end
        end
        @(posedge clk);
        #1 wr_if.wr_valid = 1'b0;
        check("burst_stall_at", stall_at, 16);
        check("burst_accepted", idx, 20);
        wait_idle("burst");
        check("burst_pulses", pulse_t.size(), 20);
        for (int i = 1; i < pulse_t.size(); i++)
            check("burst_spacing", pulse_t[i] - pulse_t[i-1], 4);

        // CR LF LF -> CR, LF
        pulse_t.delete();
        push_byte(8'h0D, a);
        push_byte(8'h0A, a);
        push_byte(8'h0A, a);
        wait_idle("crlf");
        check("crlf_pulses", pulse_t.size(), 2);

        // CR, idle gap, LF still collapses
        pulse_t.delete();
        push_byte(8'h0D, a);
        wait_idle("cr_gap");
        push_byte(8'h0A, a);
        wait_idle("lf_gap");
        check("cr_gap_pulses", pulse_t.size(), 1);

        // TAB -> four spaces, GUARD+1 cycles apart
        pulse_t.delete();
        push_byte(8'h09, acc);
        wait_idle("tab");
        check("tab_pulses", pulse_t.size(), TABN);
        for (int i = 0; i < pulse_t.size(); i++)
            check("tab_cycle", pulse_t[i] - acc, 2 + (GUARD + 1) * i);

        // High-bit drops
        pulse_t.delete();
        push_byte(8'h80, a);
        push_byte(8'hFF, a);
        wait_idle("drop");
        check("drop_pulses", pulse_t.size(), 0);
        check("drop_count", 32'(drop_count), 32'(drop_exp));

        // Scroll stall after a CR write with three bytes queued
        pulse_t.delete();
        fork
            begin
                push_byte(8'h0D, a);
                push_byte(8'h61, a);
                push_byte(8'h62, a);
                push_byte(8'h63, a);
            end
            begin
                int w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!font_we && w < 100);
                check("stall_cr_pulse", 32'(font_we), 32'd1);
                @(posedge clk);
                #1 scroll = 1'b1;
            end
        join
        n0 = pulse_t.size();
        busy_low = 0;
        repeat (900) begin
            @(negedge clk);
            if (!busy) busy_low++;
        end
        check("stall_busy", busy_low, 0);
        check("stall_no_pulse", pulse_t.size(), n0);
        @(posedge clk);
        #1 scroll = 1'b0;
        m = cyc;
        t = 0;
        while (pulse_t.size() <= n0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (pulse_t.size() > n0) check("stall_resume_gap", 32'(pulse_t[n0] - m >= 1), 32'd1);
        else check("stall_resume_timeout", pulse_t.size(), n0 + 1);
        wait_idle("stall");
        check("stall_pulses", pulse_t.size(), 4);

        // Reset mid-TAB with a full FIFO
        pulse_t.delete();
        push_byte(8'h09, a);
        t = 0;
        while (pulse_t.size() < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 scroll = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'h41 + 8'(i), a);
        @(negedge clk);
        check("midrst_full", 32'(wr_if.wr_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_font_we", 32'(font_we), 32'd0);
        check("midrst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        scroll = 1'b0;
        exp_q.delete();
        m_prev_cr = 1'b0;
        drop_exp = 0;

        // Clean restart after reset
        pulse_t.delete();
        push_byte(8'h42, a);
        wait_idle("post_rst");
        check("post_rst_pulses", pulse_t.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
